// File: rtl/seq_stage_ctrl_if.sv
// Memory-side handshake bundle for the SEQ sequencer: instruction fetch and data access.
// The master drives the requests; the slave returns ready/error with fetch-decode results.
interface seq_stage_ctrl_if;
  logic [3:0] icode;
  logic       instr_valid;
  logic       imem_req;
  logic       imem_ready;
  logic       imem_error;
  logic       dmem_req;
  logic       dmem_ready;
  logic       dmem_error;

  modport master (
    output imem_req, dmem_req,
    input  icode, instr_valid, imem_ready, imem_error, dmem_ready, dmem_error
  );

  modport slave (
    input  imem_req, dmem_req,
    output icode, instr_valid, imem_ready, imem_error, dmem_ready, dmem_error
  );
endinterface

// File: rtl/seq_stage_ctrl.sv
// SEQ Y86-64 stage sequencer: 5 cycles/insn (6 with memory) at zero wait, +1 per wait cycle.
// Holds in FETCH/MEMORY until ready; a stalled request faults to ADR after MEM_TIMEOUT cycles.
module seq_stage_ctrl #(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int          CNT_W       = 32,
  parameter int          MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [63:0]       updated_pc,
  seq_stage_ctrl_if.master  mem,
  output logic [63:0]       pc,
  output logic [5:0]        stage_en,
  output logic [2:0]        stat,
  output logic              busy,
  output logic [CNT_W-1:0]  insn_count
);

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY,
    S_WRITEBACK, S_PCUPD, S_HALT, S_ERROR
  } state_t;

  state_t             state_q, state_d;
  logic [63:0]        pc_q, pc_d;
  logic [2:0]         stat_q, stat_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [3:0]         icode_q, icode_d;
  logic               imem_req_c, dmem_req_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      stat_q  <= STAT_AOK;
      cnt_q   <= '0;
      wait_q  <= '0;
      icode_q <= 4'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stat_q  <= stat_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      icode_q <= icode_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    stat_d     = stat_q;
    cnt_d      = cnt_q;
    wait_d     = wait_q;
    icode_d    = icode_q;
    stage_en   = 6'b0;
    imem_req_c = 1'b0;
    dmem_req_c = 1'b0;
    busy       = 1'b1;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = S_FETCH;
          wait_d  = '0;
        end
      end
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (mem.imem_ready) begin
          wait_d = '0;
          if (mem.imem_error) begin
            stat_d  = STAT_ADR;
            state_d = S_ERROR;
          end else if (!mem.instr_valid) begin
            stat_d  = STAT_INS;
            state_d = S_ERROR;
          end else if (mem.icode == 4'h0) begin
            // halt retires but leaves pc pointing at itself
            stat_d  = STAT_HLT;
            cnt_d   = cnt_q + 1'b1;
            state_d = S_HALT;
          end else begin
            stage_en[0] = 1'b1;
            icode_d     = mem.icode;
            state_d     = S_DECODE;
          end
        end else if (wait_q == WAIT_LAST) begin
          stat_d  = STAT_ADR;
          state_d = S_ERROR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DECODE: begin
        stage_en[1] = 1'b1;
        state_d     = S_EXECUTE;
      end
      S_EXECUTE: begin
        stage_en[2] = 1'b1;
        // rmmovq, mrmovq, call, ret, pushq, popq touch data memory
        case (icode_q)
          4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: begin
            state_d = S_MEMORY;
            wait_d  = '0;
          end
          default: state_d = S_WRITEBACK;
        endcase
      end
      S_MEMORY: begin
        dmem_req_c = 1'b1;
        if (mem.dmem_ready) begin
          wait_d = '0;
          if (mem.dmem_error) begin
            stat_d  = STAT_ADR;
            state_d = S_ERROR;
          end else begin
            stage_en[3] = 1'b1;
            state_d     = S_WRITEBACK;
          end
        end else if (wait_q == WAIT_LAST) begin
          stat_d  = STAT_ADR;
          state_d = S_ERROR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WRITEBACK: begin
        stage_en[4] = 1'b1;
        state_d     = S_PCUPD;
      end
      S_PCUPD: begin
        stage_en[5] = 1'b1;
        pc_d        = updated_pc;
        cnt_d       = cnt_q + 1'b1;
        wait_d      = '0;
        state_d     = S_FETCH;
      end
      S_HALT, S_ERROR: busy = 1'b0;
      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign mem.imem_req = imem_req_c;
  assign mem.dmem_req = dmem_req_c;
  assign pc           = pc_q;
  assign stat         = stat_q;
  assign insn_count   = cnt_q;

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Directed bench for seq_stage_ctrl: stage sequencing, memory waits, halt, faults, timeouts, reset.
module tb_seq_stage_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [63:0] updated_pc;
  logic [63:0] pc;
  logic [5:0]  stage_en;
  logic [2:0]  stat;
  logic        busy;
  logic [31:0] insn_count;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int c0;
  int ncyc;
  logic [5:0] opq_seq [5] = '{6'h01, 6'h02, 6'h04, 6'h10, 6'h20};

  seq_stage_ctrl_if mif();

  seq_stage_ctrl #(
    .RESET_PC   (64'h100),
    .CNT_W      (32),
    .MEM_TIMEOUT(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .updated_pc (updated_pc),
    .mem        (mif),
    .pc         (pc),
    .stage_en   (stage_en),
    .stat       (stat),
    .busy       (busy),
    .insn_count (insn_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    start           = 1'b0;
    updated_pc      = 64'h0;
    mif.icode       = 4'h0;
    mif.instr_valid = 1'b0;
    mif.imem_ready  = 1'b0;
    mif.imem_error  = 1'b0;
    mif.dmem_ready  = 1'b0;
    mif.dmem_error  = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Retire one instruction with zero-wait memory; returns cycles until back in FETCH.
  task automatic run_insn(input logic [3:0] ic, input logic [63:0] npc, output int n);
    mif.icode       = ic;
    mif.instr_valid = 1'b1;
    mif.imem_ready  = 1'b1;
    mif.imem_error  = 1'b0;
    mif.dmem_ready  = 1'b1;
    mif.dmem_error  = 1'b0;
    updated_pc      = npc;
    n = 0;
    do begin
      tick();
      n++;
    end while (mif.imem_req !== 1'b1 && n < 30);
    mif.imem_ready = 1'b0;
    mif.dmem_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // reset state
    clear_inputs();
    rst_n = 1'b0;
    start = 1'b1;
    tick();
    tick();
    chk("rst_pc", pc, 64'h100);
    chk("rst_stat", stat, 1);
    chk("rst_cnt", insn_count, 0);
    chk("rst_stage_en", stage_en, 0);
    chk("rst_imem_req", mif.imem_req, 0);
    chk("rst_dmem_req", mif.dmem_req, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    start = 1'b0;
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_imem_req", mif.imem_req, 0);
    start_run();

    // OPq, zero-wait memory
    mif.icode = 4'h6; mif.instr_valid = 1'b1; mif.imem_ready = 1'b1;
    mif.dmem_ready = 1'b1; updated_pc = 64'h2;
    settle();
    chk("opq_imem_req", mif.imem_req, 1);
    chk("opq_busy", busy, 1);
    for (int k = 0; k < 5; k++) begin
      settle();
      chk($sformatf("opq_stage_en_%0d", k), stage_en, opq_seq[k]);
      chk($sformatf("opq_dmem_req_%0d", k), mif.dmem_req, 0);
      if (k == 4) chk("opq_pc_before_commit", pc, 64'h100);
      tick();
    end
    chk("opq_pc", pc, 64'h2);
    chk("opq_cnt", insn_count, 1);
    chk("opq_back_in_fetch", mif.imem_req, 1);

    // mrmovq with three data wait cycles
    c0 = cyc;
    mif.icode = 4'h5; mif.imem_ready = 1'b1; mif.dmem_ready = 1'b0; updated_pc = 64'hA;
    settle();
    chk("mr_stage_f", stage_en, 6'h01);
    tick(); tick();
    chk("mr_stage_e", stage_en, 6'h04);
    mif.imem_ready = 1'b0;
    tick();
    for (int m = 0; m < 4; m++) begin
      mif.dmem_ready = (m == 3);
      settle();
      chk($sformatf("mr_dmem_req_%0d", m), mif.dmem_req, 1);
      chk($sformatf("mr_imem_req_%0d", m), mif.imem_req, 0);
      chk($sformatf("mr_stage_m_%0d", m), stage_en, (m == 3) ? 6'h08 : 6'h00);
      tick();
    end
    mif.dmem_ready = 1'b0;
    chk("mr_wb_dmem_req", mif.dmem_req, 0);
    chk("mr_stage_w", stage_en, 6'h10);
    tick();
    chk("mr_stage_pc", stage_en, 6'h20);
    tick();
    chk("mr_pc", pc, 64'hA);
    chk("mr_cnt", insn_count, 2);
    chk("mr_cycles", cyc - c0, 9);

    // rmmovq: two fetch wait cycles, data ready on the 16th wait cycle
    mif.icode = 4'h4; updated_pc = 64'h14; mif.imem_ready = 1'b0;
    for (int w = 0; w < 2; w++) begin
      settle();
      chk($sformatf("fw_imem_req_%0d", w), mif.imem_req, 1);
      chk($sformatf("fw_stage_en_%0d", w), stage_en, 0);
      tick();
    end
    mif.imem_ready = 1'b1;
    settle();
    chk("fw_stage_f", stage_en, 6'h01);
    tick();
    mif.imem_ready = 1'b0;
    tick(); tick();
    for (int m = 0; m < 16; m++) begin
      mif.dmem_ready = (m == 15);
      settle();
      chk($sformatf("m16_dmem_req_%0d", m), mif.dmem_req, 1);
      if (m == 15) chk("m16_stage_m", stage_en, 6'h08);
      tick();
    end
    mif.dmem_ready = 1'b0;
    chk("m16_stat", stat, 1);
    chk("m16_stage_w", stage_en, 6'h10);
    tick(); tick();
    chk("m16_pc", pc, 64'h14);
    chk("m16_cnt", insn_count, 3);

    // halt at pc 0x14
    mif.icode = 4'h0; mif.imem_ready = 1'b1; mif.instr_valid = 1'b1;
    settle();
    chk("hlt_no_stage", stage_en, 0);
    tick();
    chk("hlt_stat", stat, 2);
    chk("hlt_busy", busy, 0);
    chk("hlt_pc", pc, 64'h14);
    chk("hlt_cnt", insn_count, 4);
    chk("hlt_imem_req", mif.imem_req, 0);
    start = 1'b1; mif.icode = 4'h6; mif.dmem_ready = 1'b1; updated_pc = 64'h99;
    for (int k = 0; k < 4; k++) tick();
    start = 1'b0;
    chk("hlt_frozen_stat", stat, 2);
    chk("hlt_frozen_pc", pc, 64'h14);
    chk("hlt_frozen_cnt", insn_count, 4);
    chk("hlt_frozen_stage", stage_en, 0);
    chk("hlt_frozen_req", mif.imem_req, 0);

    // illegal instruction
    do_reset();
    start_run();
    mif.icode = 4'h6; mif.imem_ready = 1'b1; mif.instr_valid = 1'b0;
    settle();
    chk("ins_no_stage", stage_en, 0);
    tick();
    chk("ins_stat", stat, 4);
    chk("ins_pc", pc, 64'h100);
    chk("ins_busy", busy, 0);
    chk("ins_imem_req", mif.imem_req, 0);
    mif.instr_valid = 1'b1; start = 1'b1;
    tick(); tick();
    start = 1'b0;
    chk("ins_frozen_stat", stat, 4);
    chk("ins_frozen_stage", stage_en, 0);

    // fetch address fault outranks illegal instruction
    do_reset();
    start_run();
    run_insn(4'h6, 64'h30, ncyc);
    mif.icode = 4'h6; mif.imem_ready = 1'b1; mif.imem_error = 1'b1; mif.instr_valid = 1'b0;
    settle();
    chk("iadr_no_stage", stage_en, 0);
    tick();
    chk("iadr_stat", stat, 3);
    chk("iadr_pc", pc, 64'h30);
    chk("iadr_cnt", insn_count, 1);

    // data address fault
    do_reset();
    start_run();
    mif.icode = 4'h9; mif.imem_ready = 1'b1; mif.instr_valid = 1'b1;
    tick(); tick(); tick();
    mif.imem_ready = 1'b0; mif.dmem_ready = 1'b1; mif.dmem_error = 1'b1;
    settle();
    chk("dadr_dmem_req", mif.dmem_req, 1);
    chk("dadr_no_stage", stage_en, 0);
    tick();
    chk("dadr_stat", stat, 3);
    chk("dadr_pc", pc, 64'h100);
    chk("dadr_dmem_req_off", mif.dmem_req, 0);

    // data memory timeout
    do_reset();
    start_run();
    mif.icode = 4'hB; mif.imem_ready = 1'b1; mif.instr_valid = 1'b1;
    tick(); tick();
    mif.imem_ready = 1'b0;
    tick();
    for (int m = 0; m < 16; m++) begin
      settle();
      chk($sformatf("dto_dmem_req_%0d", m), mif.dmem_req, 1);
      chk($sformatf("dto_stat_%0d", m), stat, 1);
      tick();
    end
    chk("dto_stat", stat, 3);
    chk("dto_dmem_req_off", mif.dmem_req, 0);
    chk("dto_busy", busy, 0);
    mif.dmem_ready = 1'b1;
    settle();
    chk("dto_late_ready_stage", stage_en, 0);
    tick();
    chk("dto_late_ready_stat", stat, 3);

    // instruction memory timeout
    do_reset();
    start_run();
    for (int m = 0; m < 16; m++) tick();
    chk("ito_stat", stat, 3);
    chk("ito_imem_req_off", mif.imem_req, 0);

    // reset while a data request is outstanding
    do_reset();
    start_run();
    run_insn(4'h6, 64'h40, ncyc);
    mif.icode = 4'h8; mif.imem_ready = 1'b1; mif.instr_valid = 1'b1;
    tick(); tick(); tick();
    mif.imem_ready = 1'b0;
    tick(); tick();
    chk("mrst_dmem_req_before", mif.dmem_req, 1);
    chk("mrst_pc_before", pc, 64'h40);
    rst_n = 1'b0;
    tick();
    chk("mrst_dmem_req", mif.dmem_req, 0);
    chk("mrst_pc", pc, 64'h100);
    chk("mrst_stat", stat, 1);
    chk("mrst_cnt", insn_count, 0);
    chk("mrst_busy", busy, 0);
    rst_n = 1'b1;
    tick();
    chk("mrst_idle_busy", busy, 0);
    start_run();
    chk("mrst_restart_req", mif.imem_req, 1);

    // per-opcode cycle count: memory ops take one extra cycle
    for (int i = 1; i < 16; i++) begin
      run_insn(i[3:0], 64'h200 + i, ncyc);
      chk($sformatf("lat_icode_%0h", i), ncyc,
          (i == 4 || i == 5 || i == 8 || i == 9 || i == 10 || i == 11) ? 6 : 5);
    end
    chk("lat_cnt", insn_count, 15);
    chk("lat_pc", pc, 64'h20F);
    chk("lat_stat", stat, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/seq_stage_ctrl.md
Name: seq_stage_ctrl

Overview:
- Multi-cycle sequencer for the SEQ Y86-64 core.
- Owns the architectural PC register and steps the datapath through fetch, decode, execute, memory, writeback and PC-update, one stage per state.
- Issues request/ready handshakes to instruction and data memory, and tracks processor status (AOK/HLT/ADR/INS).
- Takes the next-PC value from the combinational PC-update logic and commits it once per retired instruction.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset
CNT_W, 32, width of retired-instruction counter
MEM_TIMEOUT, 16, max wait cycles on a memory request before ADR fault (min 1)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous, active-low reset
start  input  1  begin execution from IDLE (level, sampled in IDLE only)
icode  input  4  instruction code from fetch logic, valid in cycle imem_ready=1
instr_valid  input  1  fetch logic: icode/ifun legal, valid with imem_ready
imem_ready  input  1  instruction memory completes current request
imem_error  input  1  instruction address fault, valid with imem_ready
dmem_ready  input  1  data memory completes current request
dmem_error  input  1  data address fault, valid with dmem_ready
updated_pc  input  64  next PC from PC-update logic
pc  output  64  current architectural PC
imem_req  output  1  instruction fetch request
dmem_req  output  1  data memory request
stage_en  output  6  one-hot stage strobe: [0]F [1]D [2]E [3]M [4]W [5]PC
stat  output  3  1=AOK 2=HLT 3=ADR 4=INS
busy  output  1  high in any state except IDLE, HALT, ERROR
insn_count  output  CNT_W  retired instructions, wraps modulo 2^CNT_W

Behaviour:
- Reset (rst_n=0 at edge) applies regardless of state, including mid-request:
  - Registers: state=IDLE, pc=RESET_PC, stat=1, insn_count=0, wait counter=0, icode_q=0.
  - Outputs: stage_en=0, imem_req=0, dmem_req=0, busy=0.
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT, ERROR. All outputs are registered-state decodes; no output depends combinationally on ready inputs except stage_en[0]/[3] (see below).
- IDLE: start=1 → FETCH next cycle.
- FETCH: imem_req=1 every cycle in state. The cycle imem_ready=1 is resolved in priority order:
  1. imem_error=1 → stat=3, go to ERROR.
  2. instr_valid=0 → stat=4, go to ERROR.
  3. icode=4'h0 (halt) → stat=2, insn_count+1, pc unchanged, go to HALT.
  4. Otherwise: stage_en[0]=1 that cycle, icode_q<=icode, go to DECODE.
- DECODE: stage_en[1]=1 → EXECUTE.
- EXECUTE: stage_en[2]=1.
  - Next state is MEMORY if icode_q ∈ {4,5,8,9,A,B} (rmmovq, mrmovq, call, ret, pushq, popq).
  - Otherwise next state is WRITEBACK.
- MEMORY: dmem_req=1 every cycle in state. On the cycle dmem_ready=1:
  - dmem_error=1 → stat=3, go to ERROR.
  - Otherwise stage_en[3]=1 that cycle, go to WRITEBACK.
- WRITEBACK: stage_en[4]=1 → PCUPD.
- PCUPD: stage_en[5]=1, pc<=updated_pc, insn_count+1 → FETCH.
- HALT, ERROR: terminal.
  - pc, stat and insn_count are frozen; start is ignored.
  - Only rst_n leaves these states.
- Wait counter:
  - Cleared on entry to FETCH/MEMORY and on the ready cycle.
  - Increments each cycle req=1 and ready=0.
  - When it reaches MEM_TIMEOUT with ready still 0 → stat=3, go to ERROR; the request is dropped next cycle.
  - ready arriving in the same cycle the count would hit MEM_TIMEOUT wins (normal completion).
- Latency with zero-wait memory:
  - Non-memory instruction: 5 cycles FETCH→FETCH.
  - Memory instruction: 6 cycles.
  - Each wait cycle adds 1.
- At most one stage_en bit is high per cycle; imem_req and dmem_req are never high together.
- dmem_ready/dmem_error are ignored outside MEMORY; imem_ready/imem_error are ignored outside FETCH.
- insn_count wraps from all-ones to 0 without affecting stat.

Test Plan:
- Reset, start=1, icode=6 (OPq), zero-wait memory, updated_pc=0x2 → stage_en sequence 01,02,04,10,20 over 5 cycles; pc=0x2 and insn_count=1 after PCUPD; dmem_req never asserted.
- icode=5 (mrmovq), dmem_ready delayed 3 cycles, updated_pc=0xA → dmem_req high 4 cycles; stage_en[3] on 4th; pc=0xA; total 9 cycles FETCH→FETCH.
- icode=0 fetched at pc=0x14 → stat=2, busy=0, pc stays 0x14, insn_count increments by 1; later start pulses and ready pulses cause no change.
- imem_ready=1 with instr_valid=0 → stat=4, ERROR; imem_error=1 instead → stat=3; in both cases pc is unchanged and no stage_en pulse is issued.
- MEMORY state with dmem_ready held 0, MEM_TIMEOUT=16 → stat=3 after 16 wait cycles, dmem_req=0 next cycle; separately, ready asserted on the 16th cycle → normal completion, stat=1.
- rst_n=0 while dmem_req=1 mid-MEMORY → next edge: dmem_req=0, pc=RESET_PC, stat=1, insn_count=0, state IDLE.
